alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 39 +++
 rtl/alu_issue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Purpose: bundles the instruction, ALU, writeback, status and debug signals of alu_issue.
// Latency: none, wiring only.
// Backpressure: instruction side is valid/ready; the ALU side is a valid strobe with no ready.
// Ports (seen from the slave = alu_issue):
//   i_instr_valid/o_instr_ready/i_instr  instruction offer and accept
//   o_alu_op/o_alu_operand0/1            ALU request (steady during EXECUTE)
//   i_alu_valid/i_alu_result             ALU response
//   o_wb_valid/o_wb_rd/o_wb_data         one-cycle writeback strobe
//   o_illegal/o_fault                    one-cycle status pulses
//   i_dbg_addr/o_dbg_data                combinational register-file read
interface alu_issue_if;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [31:0] i_instr;
  logic [2:0]  o_alu_op;
  logic [31:0] o_alu_operand0;
  logic [31:0] o_alu_operand1;
  logic        i_alu_valid;
  logic [31:0] i_alu_result;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_illegal;
  logic        o_fault;
  logic [4:0]  i_dbg_addr;
  logic [31:0] o_dbg_data;

  modport slave (
    input  i_instr_valid, i_instr, i_alu_valid, i_alu_result, i_dbg_addr,
    output o_instr_ready, o_alu_op, o_alu_operand0, o_alu_operand1,
           o_wb_valid, o_wb_rd, o_wb_data, o_illegal, o_fault, o_dbg_data
  );

  modport master (
    output i_instr_valid, i_instr, i_alu_valid, i_alu_result, i_dbg_addr,
    input  o_instr_ready, o_alu_op, o_alu_operand0, o_alu_operand1,
           o_wb_valid, o_wb_rd, o_wb_data, o_illegal, o_fault, o_dbg_data
  );
endinterface

// File: rtl/alu_issue.sv
// Purpose: single-issue RV32I ALU sequencer (ADD/SUB/XOR/AND/SRA and immediates) with a 32x32 register file.
// Latency: accept on edge N, DECODE N+1, EXECUTE N+2 (or longer while the ALU stalls), WRITEBACK N+3, ready N+4.
// Backpressure: o_instr_ready only in IDLE; ALU stalls are tolerated up to TIMEOUT EXECUTE cycles, then o_fault.
// Ports: i_clk, i_rst_n (async active-low) plus the alu_issue_if slave modport (see rtl/alu_issue_if.sv).
module alu_issue #(
  parameter int TIMEOUT = 7  // 1..15 EXECUTE cycles without i_alu_valid before faulting
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  alu_issue_if.slave  bus
);

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_instr;
  logic [2:0]  r_alu_op;
  logic [31:0] r_op0;
  logic [31:0] r_op1;
  logic [3:0]  r_wait_cnt;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_illegal;
  logic        r_fault;
  logic [31:0] r_rf [32];

  // instruction fields
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm;

  logic        w_dec_legal;
  logic [2:0]  w_dec_op;
  logic [31:0] w_dec_op1;

  logic        w_accept;
  logic        w_timeout;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_funct3 = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_funct7 = r_instr[31:25];

  // x0 is never written, so r_rf[0] always holds zero
  assign w_rs1_val = r_rf[w_rs1];
  assign w_rs2_val = r_rf[w_rs2];
  assign w_imm     = {{20{r_instr[31]}}, r_instr[31:20]};

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign bus.o_instr_ready = (r_state == S_IDLE) && i_rst_n;
  assign w_accept          = bus.i_instr_valid && bus.o_instr_ready;
  assign w_timeout         = (r_wait_cnt == WAIT_LAST);

  // ALU request is only visible during EXECUTE so the ALU sees a clean idle bus otherwise.
  assign bus.o_alu_op       = (r_state == S_EXECUTE) ? r_alu_op : OP_IDLE;
  assign bus.o_alu_operand0 = (r_state == S_EXECUTE) ? r_op0 : 32'd0;
  assign bus.o_alu_operand1 = (r_state == S_EXECUTE) ? r_op1 : 32'd0;

  assign bus.o_wb_valid = r_wb_valid;
  assign bus.o_wb_rd    = r_wb_rd;
  assign bus.o_wb_data  = r_wb_data;
  assign bus.o_illegal  = r_illegal;
  assign bus.o_fault    = r_fault;

  // Debug read sees the array directly, so a register being written shows its old value until the edge.
  assign bus.o_dbg_data = (bus.i_dbg_addr == 5'd0) ? 32'd0 : r_rf[bus.i_dbg_addr];

  // Decoder: works on the latched instruction, only consumed in DECODE.
  always_comb begin
    w_dec_legal = 1'b0;
    w_dec_op    = OP_IDLE;
    w_dec_op1   = w_rs2_val;
    case (w_opcode)
      OPC_R: begin
        w_dec_op1 = w_rs2_val;
        case ({w_funct7, w_funct3})
          10'b0000000_000: begin w_dec_legal = 1'b1; w_dec_op = OP_ADD; end
          10'b0100000_000: begin w_dec_legal = 1'b1; w_dec_op = OP_SUB; end
          10'b0000000_100: begin w_dec_legal = 1'b1; w_dec_op = OP_XOR; end
          10'b0000000_111: begin w_dec_legal = 1'b1; w_dec_op = OP_AND; end
          10'b0100000_101: begin
            w_dec_legal = 1'b1;
            w_dec_op    = OP_SRA;
            w_dec_op1   = {27'd0, w_rs2_val[4:0]};
          end
          default: ;
        endcase
      end
      OPC_I: begin
        w_dec_op1 = w_imm;
        case (w_funct3)
          3'b000: begin w_dec_legal = 1'b1; w_dec_op = OP_ADD; end
          3'b100: begin w_dec_legal = 1'b1; w_dec_op = OP_XOR; end
          3'b111: begin w_dec_legal = 1'b1; w_dec_op = OP_AND; end
          3'b101: begin
            if (w_funct7 == 7'b0100000) begin
              w_dec_legal = 1'b1;
              w_dec_op    = OP_SRA;
              w_dec_op1   = {27'd0, r_instr[24:20]};
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = w_dec_legal ? S_EXECUTE : S_IDLE;
      end
      S_EXECUTE: begin
        if (bus.i_alu_valid)  w_next = S_WRITEBACK;
        else if (w_timeout)   w_next = S_IDLE;
      end
      S_WRITEBACK: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, pulses and register file
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr    <= '0;
      r_alu_op   <= OP_IDLE;
      r_op0      <= '0;
      r_op1      <= '0;
      r_wait_cnt <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      // pulses last exactly one cycle unless re-armed below
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_instr <= bus.i_instr;
        end
        S_DECODE: begin
          if (w_dec_legal) begin
            r_alu_op   <= w_dec_op;
            r_op0      <= w_rs1_val;
            r_op1      <= w_dec_op1;
            r_wait_cnt <= '0;
          end else begin
            r_illegal <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (bus.i_alu_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= w_rd;
            r_wb_data  <= bus.i_alu_result;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_WRITEBACK: begin
          if (r_wb_rd != 5'd0) r_rf[r_wb_rd] <= r_wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule
